dht11_frame_rx: RTL and testbench
=================================

# dht11_frame_rx

Single-wire DHT11 protocol engine that sits directly upstream of the `myip_dht11` AXI4-Lite register block. On a start request it issues the host start pulse, checks the sensor response, times 40 data bits, verifies the checksum, and presents humidity and temperature bytes plus status flags for the slave registers to read.

## Interface
Parameters:
- CLK_FREQ_HZ, 100_000_000: `s00_axi_aclk` frequency. Must be a multiple of 1 MHz. It sets the 1 µs tick prescaler.
- START_LOW_US, 18000: length of the host low pulse in µs. Must be below 32768.
- TIMEOUT_US, 200: maximum µs allowed in any sensor-driven phase.
- BIT1_THRESH_US, 50: a data high phase longer than this many µs decodes as 1.

Ports:
- s00_axi_aclk  in  1  the single clock.
- s00_axi_aresetn  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle read request from the register block. Ignored while busy.
- dht_in  in  1  raw sensor line, asynchronous to the clock.
- dht_drive_low  out  1  1 = pull the line low through the IOBUF tristate; 0 = line released.
- busy  out  1  a transaction is in progress.
- done  out  1  one-cycle pulse when a transaction ends, whether good or failed.
- hum_int, hum_dec, tmp_int, tmp_dec  out  8 each  data bytes from the last frame that passed its checksum.
- chk_err  out  1  the last frame failed its checksum.
- tmo_err  out  1  the last transaction timed out.

## Operation
- dht_in passes through a 2-FF synchronizer; the engine works only on the synchronized value `s`. Rise and fall events come from comparing `s` with its previous value.
- A 1 µs tick is generated every CLK_FREQ_HZ/1e6 cycles. `us_cnt` is 15 bits, clears on every state entry, increments on each tick, and saturates.
- FSM states and transitions:
  - IDLE → START_LOW when start is seen. On entry: busy=1, and chk_err and tmo_err clear.
  - START_LOW: dht_drive_low=1. Leaves to WAIT_ACK when us_cnt reaches START_LOW_US.
  - WAIT_ACK: line released. Leaves to ACK_LOW on a fall of `s`.
  - ACK_LOW: leaves to ACK_HIGH on a rise.
  - ACK_HIGH: leaves to BIT_LOW on a fall.
  - BIT_LOW: leaves to BIT_HIGH on a rise.
  - BIT_HIGH: on a fall, shift bit (us_cnt > BIT1_THRESH_US) into a 40-bit shift register, MSB first, and increment the 6-bit bit counter. Go to CHECK if this was the 40th bit, otherwise back to BIT_LOW.
  - CHECK (one cycle): if (b0+b1+b2+b3) mod 256 equals b4, load hum_int=b0, hum_dec=b1, tmp_int=b2, tmp_dec=b3. Otherwise set chk_err and leave the data outputs unchanged. Pulse done, clear busy, go to IDLE.
  - Timeout: in WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW or BIT_HIGH, if us_cnt reaches TIMEOUT_US, set tmo_err, pulse done, clear busy and go to IDLE. Data outputs are unchanged.
- A start arriving in any state other than IDLE is dropped and not queued.
- The sensor's trailing 50 µs low after bit 40 is not tracked. The next start is accepted from IDLE regardless of the line level.

## Timing
- Reset values: every output is 0, dht_drive_low=0 (line released), state=IDLE, shift register and counters are 0. Reset is honoured mid-transaction: the line is released in the same cycle and no done pulse is produced.
- start at cycle N: busy=1 and dht_drive_low=1 at cycle N+1.
- Pin-to-event latency is 2 cycles for synchronization plus 1 cycle for edge detection.
- A fall of `s` ending bit 40 at cycle M: the CHECK state occupies cycle M+1, with done=1 and the updated outputs and flags visible at cycle M+1. At M+2, busy=0 and done=0.
- done is exactly one cycle wide and coincides with the flag and data update.
- µs resolution is one tick. A high phase measured at exactly BIT1_THRESH_US decodes as 0.

## Test plan
- Good frame at 55.0 %RH / 24.3 °C: the sensor model sends bytes 0x37, 0x00, 0x18, 0x03, 0x52 with 0 = 26 µs high and 1 = 70 µs high → one done pulse; hum_int=0x37, hum_dec=0x00, tmp_int=0x18, tmp_dec=0x03; chk_err=0, tmo_err=0.
- Bad checksum: the same frame with byte 4 = 0x53 → done pulse, chk_err=1, data outputs still 0x37/0x00/0x18/0x03 from the previous frame.
- No sensor (line held high): start → dht_drive_low high for START_LOW_US, then after TIMEOUT_US (200 µs) in WAIT_ACK → done, tmo_err=1, busy=0.
- Sensor stalls high for 250 µs during bit 17 → tmo_err=1, data unchanged. A following good frame clears tmo_err and updates the data.
- start pulsed again mid-frame → ignored; exactly one done pulse for the transaction.
- s00_axi_aresetn asserted during BIT_HIGH → dht_drive_low=0 and every output 0 immediately, no done pulse. After release, a new start yields a correct frame.

Source files
------------

// File: rtl/dht11_frame_rx.sv
// DHT11 single-wire frame receiver: host start pulse, ack check,
// 40-bit pulse-width decode and checksum gate for the register block.
module dht11_frame_rx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int START_LOW_US   = 18000,
  parameter int TIMEOUT_US     = 200,
  parameter int BIT1_THRESH_US = 50
) (
  input  logic       s00_axi_aclk,
  input  logic       s00_axi_aresetn,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_drive_low,
  output logic       busy,
  output logic       done,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] tmp_int,
  output logic [7:0] tmp_dec,
  output logic       chk_err,
  output logic       tmo_err
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [14:0]   START_M1 = 15'(START_LOW_US - 1);
  localparam logic [14:0]   TMO_M1   = 15'(TIMEOUT_US - 1);
  localparam logic [14:0]   THRESH   = 15'(BIT1_THRESH_US);

  typedef enum logic [2:0] {
    IDLE, START_LOW, WAIT_ACK, ACK_LOW,
    ACK_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  state_t        state, nxt;
  logic [1:0]    sync_q;
  logic          s, s_prev, rise, fall;
  logic [PW-1:0] pre;
  logic          tick, tmo, sensed, last;
  logic [14:0]   us_cnt, us_inc;
  logic [5:0]    bit_cnt;
  logic [39:0]   sr, sr_nxt;
  logic [7:0]    sum;

  assign s      = sync_q[1];
  assign rise   = s & ~s_prev;
  assign fall   = ~s & s_prev;
  assign tick   = (pre == PRE_MAX);
  assign us_inc = (tick && us_cnt != '1) ? us_cnt + 15'd1 : us_cnt;
  assign tmo    = tick && (us_cnt == TMO_M1);
  assign last   = (bit_cnt == 6'd39);
  assign sr_nxt = {sr[38:0], us_cnt > THRESH};
  assign sum    = sr_nxt[39:32] + sr_nxt[31:24]
                + sr_nxt[23:16] + sr_nxt[15:8];
  assign sensed = state inside {WAIT_ACK, ACK_LOW, ACK_HIGH,
                                BIT_LOW, BIT_HIGH};

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (start) nxt = START_LOW;
      START_LOW: if (tick && us_cnt == START_M1) nxt = WAIT_ACK;
      WAIT_ACK:  if (fall) nxt = ACK_LOW;
                 else if (tmo) nxt = IDLE;
      ACK_LOW:   if (rise) nxt = ACK_HIGH;
                 else if (tmo) nxt = IDLE;
      ACK_HIGH:  if (fall) nxt = BIT_LOW;
                 else if (tmo) nxt = IDLE;
      BIT_LOW:   if (rise) nxt = BIT_HIGH;
                 else if (tmo) nxt = IDLE;
      BIT_HIGH:  if (fall) nxt = last ? CHECK : BIT_LOW;
                 else if (tmo) nxt = IDLE;
      CHECK:     nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state         <= IDLE;
      sync_q        <= '0;
      s_prev        <= 1'b0;
      pre           <= '0;
      us_cnt        <= '0;
      bit_cnt       <= '0;
      sr            <= '0;
      dht_drive_low <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hum_int       <= '0;
      hum_dec       <= '0;
      tmp_int       <= '0;
      tmp_dec       <= '0;
      chk_err       <= 1'b0;
      tmo_err       <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], dht_in};
      s_prev <= s;
      state  <= nxt;
      done   <= 1'b0;
      // prescaler restarts with us_cnt so each phase is timed from entry
      if (nxt != state) begin
        pre    <= '0;
        us_cnt <= '0;
      end else begin
        pre    <= tick ? '0 : pre + 1'b1;
        us_cnt <= us_inc;
      end
      if (state == IDLE && start) begin
        busy          <= 1'b1;
        dht_drive_low <= 1'b1;
        chk_err       <= 1'b0;
        tmo_err       <= 1'b0;
        bit_cnt       <= '0;
      end
      if (state == START_LOW && nxt == WAIT_ACK)
        dht_drive_low <= 1'b0;
      if (state == BIT_HIGH && fall) begin
        sr      <= sr_nxt;
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (nxt == CHECK) begin
        done <= 1'b1;
        if (sum == sr_nxt[7:0]) begin
          hum_int <= sr_nxt[39:32];
          hum_dec <= sr_nxt[31:24];
          tmp_int <= sr_nxt[23:16];
          tmp_dec <= sr_nxt[15:8];
        end else begin
          chk_err <= 1'b1;
        end
      end
      if (state == CHECK)
        busy <= 1'b0;
      if (sensed && nxt == IDLE) begin
        tmo_err <= 1'b1;
        done    <= 1'b1;
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dht11_frame_rx.sv
// Randomized DHT11 sensor model with a transaction-level scoreboard
// checked against the receiver outputs every cycle.
module tb_dht11_frame_rx;

  localparam int DIV   = 2;
  localparam int S_US  = 60;
  localparam int T_US  = 200;
  localparam int TH_US = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sens = 1'b1;
  logic       dht_in;
  logic       dht_drive_low, busy, done, chk_err, tmo_err;
  logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc = -1000000;
  int exp_done = -1;
  int last_done = -1;
  bit m_txn = 0;
  bit m_chk = 0, m_tmo = 0;
  bit p_load = 0, p_chk = 0, p_tmo = 0;
  bit e_dl, e_busy;
  logic [31:0] m_b = '0, p_b = '0;

  assign dht_in = sens & ~dht_drive_low;

  dht11_frame_rx #(
    .CLK_FREQ_HZ(DIV * 1_000_000),
    .START_LOW_US(S_US),
    .TIMEOUT_US(T_US),
    .BIT1_THRESH_US(TH_US)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(rst_n),
    .start(start),
    .dht_in(dht_in),
    .dht_drive_low(dht_drive_low),
    .busy(busy),
    .done(done),
    .hum_int(hum_int),
    .hum_dec(hum_dec),
    .tmp_int(tmp_int),
    .tmp_dec(tmp_dec),
    .chk_err(chk_err),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit fr_good(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  function automatic logic [39:0] rand_frame(input bit good);
    logic [39:0] f;
    int s;
    f[39:8] = $urandom;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    f[7:0] = 8'(s % 256);
    if (!good) f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
    return f;
  endfunction

  // per-cycle scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_txn && cyc == acc + 1) begin
        m_chk = 0;
        m_tmo = 0;
      end
      if (cyc == exp_done) begin
        if (p_load) m_b = p_b;
        if (p_chk) m_chk = 1;
        if (p_tmo) m_tmo = 1;
        last_done = cyc;
      end
      e_dl = m_txn && cyc >= acc + 1 && cyc <= acc + S_US * DIV;
      e_busy = m_txn && cyc >= acc + 1 &&
               !(exp_done >= 0 && cyc >= exp_done + (p_tmo ? 0 : 1));
      chk("drive_low", dht_drive_low, e_dl);
      chk("busy", busy, e_busy);
      chk("done", done, cyc == exp_done);
      chk("data", {hum_int, hum_dec, tmp_int, tmp_dec}, m_b);
      chk("chk_err", chk_err, m_chk);
      chk("tmo_err", tmo_err, m_tmo);
      if (exp_done >= 0 && cyc >= exp_done + 1) begin
        m_txn = 0;
        exp_done = -1;
      end
    end
  end

  task automatic wait_us(input int n);
    repeat (n * DIV) @(posedge clk);
  endtask

  task automatic set_line(input logic v);
    @(posedge clk);
    #1;
    sens = v;
  endtask

  task automatic do_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    if (!m_txn) begin
      m_txn = 1;
      acc = cyc;
      exp_done = -1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_dl"}, dht_drive_low, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_data"}, {hum_int, hum_dec, tmp_int, tmp_dec}, 0);
    chk({nm, "_chk"}, chk_err, 0);
    chk({nm, "_tmo"}, tmo_err, 0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_txn = 0;
    exp_done = -1;
    acc = -1000000;
    m_b = '0;
    m_chk = 0;
    m_tmo = 0;
    #1;
    check_zero("rst_mid");
    sens = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // mode 0: 26/70 us highs, 1: random widths, 2: 50/51 us boundary
  task automatic send_frame(input logic [39:0] f, input int mode,
                            input int stall_bit, input int rst_bit,
                            input int mid_bit);
    int h;
    int r;
    do_start();
    repeat (S_US * DIV + 2) @(posedge clk);
    wait_us($urandom_range(20, 40));
    set_line(1'b0);
    wait_us(80);
    set_line(1'b1);
    wait_us(80);
    for (int i = 0; i < 40; i++) begin
      set_line(1'b0);
      wait_us($urandom_range(15, 25));
      set_line(1'b1);
      r = cyc;
      if (i == stall_bit) begin
        p_load = 0;
        p_chk = 0;
        p_tmo = 1;
        exp_done = r + 3 + T_US * DIV;
        wait_us(250);
        return;
      end
      if (i == rst_bit) begin
        wait_us(10);
        apply_reset();
        return;
      end
      if (i == mid_bit) do_start();
      if (mode == 1)
        h = f[39-i] ? $urandom_range(60, 80) : $urandom_range(15, 35);
      else if (mode == 2)
        h = f[39-i] ? TH_US + 1 : TH_US;
      else
        h = f[39-i] ? 70 : 26;
      wait_us(h);
    end
    p_b = f[39:8];
    p_load = fr_good(f);
    p_chk = !p_load;
    p_tmo = 0;
    set_line(1'b0);
    exp_done = cyc + 3;
    wait_us(50);
    set_line(1'b1);
    wait_us(20);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    send_frame(40'h37_00_18_03_52, 0, -1, -1, -1);
    repeat (10) @(posedge clk);
    chk("litA_hum_int", hum_int, 8'h37);
    chk("litA_hum_dec", hum_dec, 8'h00);
    chk("litA_tmp_int", tmp_int, 8'h18);
    chk("litA_tmp_dec", tmp_dec, 8'h03);
    chk("litA_flags", {chk_err, tmo_err}, 2'b00);

    send_frame(40'h37_00_18_03_53, 0, -1, -1, -1);
    repeat (10) @(posedge clk);
    chk("litB_chk_err", chk_err, 1);
    chk("litB_data", {hum_int, hum_dec, tmp_int, tmp_dec}, 32'h37001803);

    do_start();
    p_load = 0;
    p_chk = 0;
    p_tmo = 1;
    exp_done = acc + 1 + (S_US + T_US) * DIV;
    repeat ((S_US + T_US) * DIV + 20) @(posedge clk);
    chk("lit_nosensor_lat", last_done - acc, 521);
    chk("lit_nosensor_tmo", tmo_err, 1);
    chk("lit_nosensor_busy", busy, 0);

    send_frame(rand_frame(1), 1, 17, -1, -1);
    repeat (20) @(posedge clk);
    chk("lit_stall_tmo", tmo_err, 1);

    send_frame(rand_frame(1), 1, -1, -1, -1);
    repeat (10) @(posedge clk);
    chk("lit_after_stall_tmo", tmo_err, 0);

    send_frame(rand_frame(1), 2, -1, -1, -1);
    repeat (10) @(posedge clk);
    send_frame(rand_frame(1), 0, -1, -1, 10);
    repeat (10) @(posedge clk);
    send_frame(rand_frame(1), 1, -1, 20, -1);
    repeat (10) @(posedge clk);

    send_frame(40'h37_00_18_03_52, 0, -1, -1, -1);
    repeat (10) @(posedge clk);
    chk("lit_post_rst_hum", hum_int, 8'h37);

    send_frame(rand_frame(1'($urandom_range(0, 1))), 1, -1, -1, -1);
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
